sram_1rw_arbiter: RTL and testbench
===================================

Name: sram_1rw_arbiter

Overview:
- Controller for a single-port 1RW SRAM macro with a 7-bit address and 46-bit data (active-low CSB/WEB/OEB, synchronous read into an output latch, tristate O gated by OEB).
- Shares the single port between two requesters, A and B, using round-robin arbitration and one access per cycle.
- Zero-initialises the whole array after every reset.
- Returns read data to the requester that issued the read.
- Sits between two client engines and the macro; the macro CE pin is tied to clk at integration.

Parameters:
- ADDR_W, 7, address width; depth is 2**ADDR_W.
- DATA_W, 46, data width.

Ports:
- clk  input  1  clock; also drives SRAM CE.
- reset  input  1  synchronous, active-high reset.
- init_done  output  1  high once the clear sweep is complete.
- a_req_valid  input  1  requester A has a request.
- a_req_ready  output  1  A's request is accepted this cycle.
- a_req_we  input  1  1 = write, 0 = read.
- a_req_addr  input  ADDR_W  A's address.
- a_req_wdata  input  DATA_W  A's write data.
- a_rsp_valid  output  1  A's read data is valid.
- a_rsp_rdata  output  DATA_W  A's read data.
- b_req_valid, b_req_ready, b_req_we, b_req_addr, b_req_wdata, b_rsp_valid, b_rsp_rdata: same as the A ports, for requester B.
- sram_a  output  ADDR_W  SRAM A.
- sram_csb  output  1  SRAM CSB.
- sram_web  output  1  SRAM WEB.
- sram_oeb  output  1  SRAM OEB.
- sram_i  output  DATA_W  SRAM I.
- sram_o  input  DATA_W  SRAM O.

Behaviour:
- Reset state:
  - Reset is synchronous and active-high on clk.
  - While reset is high, outputs are forced: sram_csb=1, sram_web=1, sram_oeb=1, sram_a=0, sram_i=0, both req_ready=0, both rsp_valid=0, both rsp_rdata=0, init_done=0.
  - Reset puts the FSM in INIT with init_ptr=0, sets the round-robin last-grant to B (so A wins first), and clears any pending response.
- FSM has two states, INIT and RUN.
- INIT:
  - Each cycle drives sram_csb=0, sram_web=0, sram_a=init_ptr, sram_i=0, sram_oeb=1, then increments init_ptr.
  - After the cycle with init_ptr = 2**ADDR_W-1, moves to RUN.
  - INIT lasts exactly 2**ADDR_W cycles (128 by default).
  - Both req_ready are 0 and init_done is 0 throughout.
- RUN:
  - init_done=1.
  - Grant rule:
    - Only one requester valid: that requester is granted.
    - Both valid: the one not granted most recently is granted.
    - Neither valid: no grant, and sram_csb=1.
  - Last-grant updates only on a grant.
  - x_req_ready = grant_x. This is combinational and depends on x_req_valid.
  - A transfer occurs when valid && ready.
  - On a grant: sram_csb=0, sram_web=~we, sram_a=addr, sram_i=wdata; the access is sampled at the next clk edge.
  - Throughput is one access per cycle. Back-to-back and alternating accesses have no bubbles.
- Read response (default build):
  - For a read granted in cycle t: in cycle t+1, sram_oeb=0, x_rsp_valid=1 for exactly one cycle, and x_rsp_rdata=sram_o.
  - sram_oeb=1 in every cycle that has no pending response.
  - rsp_rdata=0 whenever rsp_valid=0.
  - There is no response backpressure; the requester must accept the data.
- Writes produce no response.
- Write to address X in cycle t followed by a read of X in cycle t+1 returns the new data.
- Reset asserted mid-operation drops any pending response (no rsp_valid) and restarts the full INIT sweep from 0. Data written earlier is lost.
- A reset of one cycle or longer always restarts INIT.
- Requests presented during INIT wait: they are held and not dropped, because ready=0.

Optional Feature:
- Macro: SRAM_ARB_RSP_REG_EN.
- Defined:
  - sram_o is captured into a DATA_W response register at the end of cycle t+1, along with the owner.
  - x_rsp_valid/x_rsp_rdata are registered and appear in cycle t+2, so read latency is 2.
  - sram_oeb is still low only in cycle t+1.
  - Reset clears the register to 0.
- Undefined: read latency is 1 and the response is combinational from sram_o, as described under Behaviour.

Test Plan:
- Deassert reset, hold all valids low: 128 cycles with csb=0, web=0, sram_a=0..127, sram_i=0; init_done rises in cycle 128; A reads addr 5 → a_rsp_valid one cycle later with rdata=0.
- After init, A writes addr 3, data 46'h0123_4567_89AB; next cycle A reads addr 3 → a_rsp_valid=1 the following cycle with rdata=46'h0123_4567_89AB; b_rsp_valid stays 0.
- A and B both hold valid reads (A addr 1, B addr 2) for 4 cycles → grants A,B,A,B with no idle cycle; responses are A,B,A,B, each one cycle after its grant; sram_oeb is low for 4 consecutive cycles.
- Only B valid (writes) for 3 cycles, then A and B valid together → B granted 3 times, then A wins; b_rsp_valid never asserts for the writes.
- A read is granted, and reset is asserted in the next cycle → no a_rsp_valid; init_ptr restarts at 0; after init_done, a read of the previously written addr 3 returns 0.
- With SRAM_ARB_RSP_REG_EN defined, repeat the second scenario → a_rsp_valid asserts 2 cycles after the read grant with the same data; sram_oeb is low only in the grant+1 cycle.

Source files
------------

// File: rtl/sram_1rw_arbiter.sv
// rtl/sram_1rw_arbiter.sv - round-robin two-requester controller for a 1RW SRAM macro with clear-on-reset
// Optional feature macro SRAM_ARB_RSP_REG_EN: registers the read response (latency 2 instead of 1).
module sram_1rw_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 46
) (
  input  logic              clk,
  input  logic              reset,
  output logic              init_done,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
  logic              last_b_q, last_b_d;
  logic              pend_valid_q, pend_valid_d;
  logic              pend_owner_q, pend_owner_d;
  logic              run;
  logic              grant_a, grant_b;

  // last_b_q set means B was granted most recently, so A wins a tie
  always_comb begin
    run     = (state_q == ST_RUN) && !reset;
    grant_a = run && a_req_valid && (!b_req_valid || last_b_q);
    grant_b = run && b_req_valid && !grant_a;
  end

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    last_b_d   = last_b_q;
    if (state_q == ST_INIT) begin
      init_ptr_d = init_ptr_q + ADDR_W'(1);
      if (init_ptr_q == {ADDR_W{1'b1}}) begin
        state_d = ST_RUN;
      end
    end
    if (grant_a) begin
      last_b_d = 1'b0;
    end else if (grant_b) begin
      last_b_d = 1'b1;
    end
    pend_valid_d = (grant_a && !a_req_we) || (grant_b && !b_req_we);
    pend_owner_d = grant_b;
  end

  always_comb begin
    sram_csb = 1'b1;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_i   = '0;
    if (!reset) begin
      if (state_q == ST_INIT) begin
        sram_csb = 1'b0;
        sram_web = 1'b0;
        sram_a   = init_ptr_q;
      end else if (grant_a) begin
        sram_csb = 1'b0;
        sram_web = ~a_req_we;
        sram_a   = a_req_addr;
        sram_i   = a_req_wdata;
      end else if (grant_b) begin
        sram_csb = 1'b0;
        sram_web = ~b_req_we;
        sram_a   = b_req_addr;
        sram_i   = b_req_wdata;
      end
    end
    sram_oeb    = !(pend_valid_q && !reset);
    init_done   = run;
    a_req_ready = grant_a;
    b_req_ready = grant_b;
  end

`ifdef SRAM_ARB_RSP_REG_EN
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_owner_q, rsp_owner_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  // The macro output is only driven while OEB is low, so capture solely in that cycle
  always_comb begin
    rsp_valid_d = pend_valid_q;
    rsp_owner_d = pend_owner_q;
    rsp_data_d  = pend_valid_q ? sram_o : '0;
    a_rsp_valid = rsp_valid_q && !rsp_owner_q && !reset;
    b_rsp_valid = rsp_valid_q && rsp_owner_q && !reset;
    a_rsp_rdata = a_rsp_valid ? rsp_data_q : '0;
    b_rsp_rdata = b_rsp_valid ? rsp_data_q : '0;
  end
`else
  always_comb begin
    a_rsp_valid = pend_valid_q && !pend_owner_q && !reset;
    b_rsp_valid = pend_valid_q && pend_owner_q && !reset;
    a_rsp_rdata = a_rsp_valid ? sram_o : '0;
    b_rsp_rdata = b_rsp_valid ? sram_o : '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      init_ptr_q   <= '0;
      last_b_q     <= 1'b1;
      pend_valid_q <= 1'b0;
      pend_owner_q <= 1'b0;
`ifdef SRAM_ARB_RSP_REG_EN
      rsp_valid_q  <= 1'b0;
      rsp_owner_q  <= 1'b0;
      rsp_data_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      last_b_q     <= last_b_d;
      pend_valid_q <= pend_valid_d;
      pend_owner_q <= pend_owner_d;
`ifdef SRAM_ARB_RSP_REG_EN
      rsp_valid_q  <= rsp_valid_d;
      rsp_owner_q  <= rsp_owner_d;
      rsp_data_q   <= rsp_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// tb/tb_sram_1rw_arbiter.sv - self-checking bench for sram_1rw_arbiter with a behavioural 1RW macro
module tb_sram_1rw_arbiter;

  localparam int AW = 7;
  localparam int DW = 46;
`ifdef SRAM_ARB_RSP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          init_done;
  logic          a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_wdata, a_rsp_rdata;
  logic          b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_wdata, b_rsp_rdata;
  logic [AW-1:0] sram_a;
  logic          sram_csb, sram_web, sram_oeb;
  logic [DW-1:0] sram_i;
  wire  [DW-1:0] sram_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  sram_1rw_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .sram_a(sram_a), .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
    .sram_i(sram_i), .sram_o(sram_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 1RW macro: synchronous access, output latch, tristate on OEB
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] dout;
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_a] <= sram_i;
      else dout <= mem[sram_a];
    end
  end
  assign sram_o = sram_oeb ? {DW{1'bz}} : dout;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          qa[$];
  rsp_t          qb[$];
  logic [DW-1:0] ref_mem [2**AW];
  logic          m_last_b;
  logic          last_oeb;
  logic          last_init_done;

  logic          ea_v, eb_v;
  logic [DW-1:0] ea_d, eb_d;
  always @(negedge clk) begin
    ea_v = 1'b0; ea_d = '0;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      ea_v = 1'b1; ea_d = qa[0].data; void'(qa.pop_front());
    end
    n_cmp++;
    if (a_rsp_valid !== ea_v || a_rsp_rdata !== ea_d) begin
      n_err++;
      $display("FAIL a_rsp cyc=%0d got v=%b d=%h expected v=%b d=%h", cyc, a_rsp_valid, a_rsp_rdata, ea_v, ea_d);
    end
    eb_v = 1'b0; eb_d = '0;
    if (qb.size() > 0 && qb[0].due == cyc) begin
      eb_v = 1'b1; eb_d = qb[0].data; void'(qb.pop_front());
    end
    n_cmp++;
    if (b_rsp_valid !== eb_v || b_rsp_rdata !== eb_d) begin
      n_err++;
      $display("FAIL b_rsp cyc=%0d got v=%b d=%h expected v=%b d=%h", cyc, b_rsp_valid, b_rsp_rdata, eb_v, eb_d);
    end
  end

  task automatic model_reset();
    m_last_b = 1'b1;
    qa.delete();
    qb.delete();
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
  endtask

  task automatic idle_inputs();
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
  endtask

  // One RUN cycle: drive, predict the grant, check ready, enqueue expected read data
  task automatic do_cycle(input logic av, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                          input logic bv, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    logic ga, gb;
    a_req_valid = av; a_req_we = aw; a_req_addr = aa; a_req_wdata = ad;
    b_req_valid = bv; b_req_we = bw; b_req_addr = ba; b_req_wdata = bd;
    ga = av && (!bv || m_last_b);
    gb = bv && !ga;
    @(negedge clk);
    n_cmp++;
    if (a_req_ready !== ga || b_req_ready !== gb) begin
      n_err++;
      $display("FAIL grant cyc=%0d got a=%b b=%b expected a=%b b=%b", cyc, a_req_ready, b_req_ready, ga, gb);
    end
    last_oeb = sram_oeb;
    last_init_done = init_done;
    if (ga) begin
      m_last_b = 1'b0;
      if (aw) ref_mem[aa] = ad;
      else qa.push_back('{due: cyc + LAT, data: ref_mem[aa]});
    end
    if (gb) begin
      m_last_b = 1'b1;
      if (bw) ref_mem[ba] = bd;
      else qb.push_back('{due: cyc + LAT, data: ref_mem[ba]});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    do_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_req_valid = 1'b1; b_req_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if ({sram_csb, sram_web, sram_oeb, a_req_ready, b_req_ready, init_done} !== 6'b111000 ||
        sram_a !== '0 || sram_i !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got csb=%b web=%b oeb=%b rdy=%b%b done=%b a=%h i=%h expected 1 1 1 00 0 0 0",
               sram_csb, sram_web, sram_oeb, a_req_ready, b_req_ready, init_done, sram_a, sram_i);
    end
    @(posedge clk); #1;
    idle_inputs();
    model_reset();
  endtask

  // Release reset and watch the clear sweep; optionally hold an A read pending throughout
  task automatic test_init(input logic hold_a, input logic [AW-1:0] addr);
    reset = 1'b0;
    a_req_valid = hold_a; a_req_we = 1'b0; a_req_addr = addr;
    for (int i = 0; i < 2**AW; i++) begin
      @(negedge clk);
      n_cmp++;
      if (sram_csb !== 1'b0 || sram_web !== 1'b0 || sram_a !== AW'(i) || sram_i !== '0 ||
          sram_oeb !== 1'b1 || init_done !== 1'b0 || a_req_ready !== 1'b0 || b_req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL init_sweep step %0d got csb=%b web=%b a=%0d i=%h oeb=%b done=%b rdy=%b%b",
                 i, sram_csb, sram_web, sram_a, sram_i, sram_oeb, init_done, a_req_ready, b_req_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_first_read();
    do_cycle(1'b1, 1'b0, 7'd5, '0, 1'b0, 1'b0, '0, '0);
    n_cmp++;
    if (last_init_done !== 1'b1) begin
      n_err++;
      $display("FAIL init_done_rise got %b expected 1", last_init_done);
    end
    idle_cycle(); idle_cycle();
  endtask

  task automatic test_write_read();
    do_cycle(1'b1, 1'b1, 7'd3, 46'h0123_4567_89AB, 1'b0, 1'b0, '0, '0);
    do_cycle(1'b1, 1'b0, 7'd3, '0, 1'b0, 1'b0, '0, '0);
    idle_cycle();
    n_cmp++;
    if (last_oeb !== 1'b0) begin
      n_err++;
      $display("FAIL oeb_grant_plus1 got %b expected 0", last_oeb);
    end
    idle_cycle();
    n_cmp++;
    if (last_oeb !== 1'b1) begin
      n_err++;
      $display("FAIL oeb_grant_plus2 got %b expected 1", last_oeb);
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    do_cycle(1'b1, 1'b1, 7'd1, 46'h1111_2222_3333, 1'b0, 1'b0, '0, '0);
    do_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 7'd2, 46'h2AAA_BBBB_CCCC);
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b1, 1'b0, 7'd1, '0, 1'b1, 1'b0, 7'd2, '0);
      if (i > 0) begin
        n_cmp++;
        if (last_oeb !== 1'b0) begin
          n_err++;
          $display("FAIL oeb_streak step %0d got %b expected 0", i, last_oeb);
        end
      end
    end
    idle_cycle();
    n_cmp++;
    if (last_oeb !== 1'b0) begin
      n_err++;
      $display("FAIL oeb_streak tail got %b expected 0", last_oeb);
    end
    idle_cycle(); idle_cycle();
  endtask

  task automatic test_b_only();
    for (int i = 0; i < 3; i++)
      do_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(10 + i), DW'(46'h0BEE_0000_0000 + i));
    do_cycle(1'b1, 1'b0, 7'd11, '0, 1'b1, 1'b1, 7'd13, 46'h3FFF_0000_FFFF);
    do_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 7'd13, 46'h3FFF_0000_FFFF);
    do_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 7'd13, '0);
    idle_cycle(); idle_cycle();
  endtask

  task automatic test_reset_mid();
    do_cycle(1'b1, 1'b0, 7'd3, '0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    n_cmp++;
    if (sram_oeb !== 1'b1 || init_done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset got oeb=%b done=%b expected oeb=1 done=0", sram_oeb, init_done);
    end
    @(posedge clk); #1;
    test_init(1'b1, 7'd3);
    do_cycle(1'b1, 1'b0, 7'd3, '0, 1'b0, 1'b0, '0, '0);
    idle_cycle(); idle_cycle(); idle_cycle();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    last_oeb = 1'b1;
    last_init_done = 1'b0;
    model_reset();
    test_reset();
    test_init(1'b0, '0);
    test_first_read();
    test_write_read();
    test_back_to_back();
    test_b_only();
    test_reset_mid();
    n_cmp++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_err++;
      $display("FAIL rsp_drain got %0d/%0d outstanding expected 0/0", qa.size(), qb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
